pu_mac_datapath: RTL and testbench
==================================

Name: pu_mac_datapath

Overview:
- Processing-unit datapath that responds to the recursive-architecture controller's PU/BRAM control strobes.
- Holds MAC_NUM parallel signed multiply-accumulate lanes with a per-cycle operand mux:
  - layer 1: din1 activations × din2 weights;
  - layer 2: temp_bram activations × din3 weights.
- On each PU valid strobe it quantises the lane accumulators. Layer-1 results go to temp_bram; layer-2 results go to the final result port.

Parameters:
MAC_NUM, 8, number of parallel MAC lanes
DATA_W, 8, signed operand/result width per lane
ACC_W, 24, signed accumulator width per lane
SHIFT, 4, arithmetic right shift applied before output quantisation

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  reset, asynchronous, active-low
mux_ctrl_i  input  1  operand select: 0 = din1/din2, 1 = temp/din3
pu_en_i  input  1  accumulate strobe; BRAM read data valid this cycle
pu_valid_i  input  1  capture strobe; end of one dot-product group
pu_clear_i  input  1  clear all lane accumulators
din1_data_i  input  MAC_NUM*DATA_W  layer-1 activations, lane i at [i*DATA_W +: DATA_W]
din2_data_i  input  MAC_NUM*DATA_W  layer-1 weights
din3_data_i  input  MAC_NUM*DATA_W  layer-2 weights
temp_rd_data_i  input  MAC_NUM*DATA_W  layer-2 activations from temp_bram
temp_wr_data_o  output  MAC_NUM*DATA_W  quantised layer-1 results to temp_bram
temp_wr_valid_o  output  1  one-cycle pulse; temp_wr_data_o valid
result_o  output  MAC_NUM*DATA_W  quantised layer-2 results
result_valid_o  output  1  one-cycle pulse; result_o valid
sat_flag_o  output  1  sticky: an accumulator saturated
out_cnt_o  output  8  count of temp_wr_valid_o pulses, wraps 255→0

Behaviour:
- Reset (async assert, sync-released by system): every output and internal register is 0, including acc[i], layer2_q, out_cnt_o and sat_flag_o. Assertion mid-accumulation zeroes outputs immediately.
- Operand mux (combinational, per cycle):
  - mux_ctrl_i=0: a=din1, w=din2.
  - mux_ctrl_i=1: a=temp_rd_data_i, w=din3.
  - All operands are signed two's complement.
- Product p[i] = a[i]*w[i], 2*DATA_W bits, sign-extended to ACC_W.
- Accumulator next value acc_n[i], by precedence:
  - pu_clear_i=1 and pu_en_i=1: p[i].
  - pu_clear_i=1 only: 0.
  - pu_en_i=1 only: sat(acc[i]+p[i]).
  - neither: hold.
- Saturation:
  - The sum is computed in ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp in any lane sets sat_flag_o to 1 on the next edge; it clears only on reset.
- Capture, when pu_valid_i=1:
  - The capture source is acc_n[i], so a same-cycle product is included.
  - q[i] = acc_n[i] >>> SHIFT (arithmetic shift).
  - If the capture is routed to layer 1, apply ReLU: negative becomes 0.
  - Then saturate to the DATA_W signed range [-128, 127] at default.
- Layer tracking, layer2_q:
  - Set on any edge where mux_ctrl_i=1.
  - Cleared on the edge after a capture performed while layer2_q=1.
  - If mux_ctrl_i=1 on that same edge, set wins.
  - Routing uses layer2_q | mux_ctrl_i sampled in the capture cycle. A controller dropping mux_ctrl in the same cycle as its final pu_valid is therefore still routed to layer 2.
- Output timing, latency 1 cycle from pu_valid_i:
  - Layer 1: temp_wr_data_o is registered; temp_wr_valid_o=1 for exactly one cycle; out_cnt_o increments.
  - Layer 2: result_o is registered; result_valid_o=1 for exactly one cycle.
  - Data registers hold their last value between pulses. Both valid pulses are never high together.
- Back-to-back pu_valid_i produces back-to-back pulses, each with its own captured data.
- pu_valid_i does not clear accumulators; only pu_clear_i does.
- No backpressure: the downstream side must accept every pulse.

Test Plan:
- Reset: hold rstn_i=0 with random inputs toggling → all outputs 0. Release, no strobes for 10 cycles → all outputs stay 0.
- Layer-1 ReLU:
  - Stimulus: mux_ctrl=0; lane0 a=3, w=5; lane1 a=-3, w=5; 4 pu_en cycles; then pu_valid.
  - Next cycle: temp_wr_valid_o=1; lane0 = 60>>>4 = 3; lane1 = 0 (ReLU).
  - out_cnt_o=1, result_valid_o=0.
- Clear+enable collision:
  - Stimulus: acc lane0=60; then a cycle with pu_clear=1, pu_en=1, a=2, w=7; then pu_valid.
  - Required: captured lane0 = 14>>>4 = 0. Repeat with a=16, w=16 → 256>>>4 = 16.
- Layer-2 signed output:
  - Stimulus: mux_ctrl=1; temp=10, din3=-2 for 8 pu_en cycles; on the final pu_valid cycle drive mux_ctrl=0.
  - Required: result_valid_o=1; lane0 = -160>>>4 = -10 (8'hF6); temp_wr_valid_o=0.
  - The next pu_valid with mux_ctrl=0 is routed to layer 1.
- Saturation (ACC_W=16):
  - Stimulus: a=127, w=127 for 3 pu_en cycles → raw sum 48387, clamped to 32767, sat_flag_o=1.
  - Capture → 2047 saturates to 127. sat_flag_o stays 1 after pu_clear.
- Async reset mid-operation:
  - Stimulus: rstn_i falls between edges during the 2nd of 4 pu_en cycles.
  - Required: outputs are 0 before the next edge. After release, a fresh 1-cycle accumulate of 4×4 then capture gives lane0 = 1, with no residue from the earlier accumulation.

Source files
------------

// File: rtl/pu_mac_datapath.sv
// PU datapath: MAC_NUM signed MAC lanes with a layer operand mux, saturating accumulators,
// and a quantising capture path that routes layer-1 results to temp_bram and layer-2 to result_o.

module pu_mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     relu_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] w_i,
    output logic        [DATA_W-1:0] q_o,
    output logic                     sat_o
);
    localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Q_MAX   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, acc, acc_n, acc_sat, shifted, relu_v;
    logic signed [ACC_W:0]      sum;
    logic                       clamp;

    always_comb begin
        prod     = (2*DATA_W)'(a_i) * (2*DATA_W)'(w_i);
        prod_ext = ACC_W'(prod);
        sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);
        clamp    = 1'b0;
        acc_sat  = sum[ACC_W-1:0];
        if (sum > ACC_MAX) begin
            acc_sat = ACC_MAX[ACC_W-1:0];
            clamp   = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_sat = ACC_MIN[ACC_W-1:0];
            clamp   = 1'b1;
        end
        // clear+enable restarts the group with this cycle's product
        if (clear_i && en_i)  acc_n = prod_ext;
        else if (clear_i)     acc_n = '0;
        else if (en_i)        acc_n = acc_sat;
        else                  acc_n = acc;
        sat_o = en_i && !clear_i && clamp;
    end

    // Capture source is acc_n so a product arriving with pu_valid is included
    always_comb begin
        shifted = acc_n >>> SHIFT;
        relu_v  = (relu_i && shifted < 0) ? '0 : shifted;
        if (relu_v > Q_MAX)      q_o = Q_MAX[DATA_W-1:0];
        else if (relu_v < Q_MIN) q_o = Q_MIN[DATA_W-1:0];
        else                     q_o = relu_v[DATA_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) acc <= '0;
        else         acc <= acc_n;
    end
endmodule

module pu_mac_datapath #(
    parameter int MAC_NUM = 8,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      mux_ctrl_i,
    input  logic                      pu_en_i,
    input  logic                      pu_valid_i,
    input  logic                      pu_clear_i,
    input  logic [MAC_NUM*DATA_W-1:0] din1_data_i,
    input  logic [MAC_NUM*DATA_W-1:0] din2_data_i,
    input  logic [MAC_NUM*DATA_W-1:0] din3_data_i,
    input  logic [MAC_NUM*DATA_W-1:0] temp_rd_data_i,
    output logic [MAC_NUM*DATA_W-1:0] temp_wr_data_o,
    output logic                      temp_wr_valid_o,
    output logic [MAC_NUM*DATA_W-1:0] result_o,
    output logic                      result_valid_o,
    output logic                      sat_flag_o,
    output logic [7:0]                out_cnt_o
);
    logic [MAC_NUM-1:0][DATA_W-1:0] a_vec, w_vec, q_vec;
    logic [MAC_NUM-1:0]             sat_vec;
    logic                           layer2_q, route_l2;

    assign a_vec    = mux_ctrl_i ? temp_rd_data_i : din1_data_i;
    assign w_vec    = mux_ctrl_i ? din3_data_i    : din2_data_i;
    // A controller may drop mux_ctrl on its last pu_valid; layer2_q keeps the routing
    assign route_l2 = layer2_q | mux_ctrl_i;

    for (genvar g = 0; g < MAC_NUM; g++) begin : g_lane
        pu_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_lane (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .en_i    (pu_en_i),
            .clear_i (pu_clear_i),
            .relu_i  (!route_l2),
            .a_i     (a_vec[g]),
            .w_i     (w_vec[g]),
            .q_o     (q_vec[g]),
            .sat_o   (sat_vec[g])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            layer2_q        <= 1'b0;
            temp_wr_data_o  <= '0;
            temp_wr_valid_o <= 1'b0;
            result_o        <= '0;
            result_valid_o  <= 1'b0;
            sat_flag_o      <= 1'b0;
            out_cnt_o       <= '0;
        end else begin
            temp_wr_valid_o <= 1'b0;
            result_valid_o  <= 1'b0;
            sat_flag_o      <= sat_flag_o | (|sat_vec);
            if (mux_ctrl_i)                  layer2_q <= 1'b1;
            else if (pu_valid_i && layer2_q) layer2_q <= 1'b0;
            if (pu_valid_i) begin
                if (route_l2) begin
                    result_o       <= q_vec;
                    result_valid_o <= 1'b1;
                end else begin
                    temp_wr_data_o  <= q_vec;
                    temp_wr_valid_o <= 1'b1;
                    out_cnt_o       <= out_cnt_o + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pu_mac_datapath.sv
// Directed self-checking bench for pu_mac_datapath (ACC_W=16 so saturation is reachable).

module tb_pu_mac_datapath;
    localparam int MAC_NUM = 8;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int SHIFT   = 4;
    localparam int VW      = MAC_NUM*DATA_W;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          mux_ctrl_i = 1'b0, pu_en_i = 1'b0, pu_valid_i = 1'b0, pu_clear_i = 1'b0;
    logic [VW-1:0] din1_data_i = '0, din2_data_i = '0, din3_data_i = '0, temp_rd_data_i = '0;
    logic [VW-1:0] temp_wr_data_o, result_o;
    logic          temp_wr_valid_o, result_valid_o, sat_flag_o;
    logic [7:0]    out_cnt_o;

    int errors = 0;
    int checks = 0;

    pu_mac_datapath #(.MAC_NUM(MAC_NUM), .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .mux_ctrl_i(mux_ctrl_i), .pu_en_i(pu_en_i),
        .pu_valid_i(pu_valid_i), .pu_clear_i(pu_clear_i),
        .din1_data_i(din1_data_i), .din2_data_i(din2_data_i), .din3_data_i(din3_data_i),
        .temp_rd_data_i(temp_rd_data_i), .temp_wr_data_o(temp_wr_data_o),
        .temp_wr_valid_o(temp_wr_valid_o), .result_o(result_o), .result_valid_o(result_valid_o),
        .sat_flag_o(sat_flag_o), .out_cnt_o(out_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [VW-1:0] lanes2(input logic [DATA_W-1:0] l0, input logic [DATA_W-1:0] l1);
        logic [VW-1:0] v;
        v = '0;
        v[DATA_W-1:0]        = l0;
        v[2*DATA_W-1:DATA_W] = l1;
        return v;
    endfunction

    // One clock with the given strobes; returns just after the edge
    task automatic cyc(input logic mux, input logic en, input logic clr, input logic vld);
        mux_ctrl_i = mux; pu_en_i = en; pu_clear_i = clr; pu_valid_i = vld;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mux_ctrl_i = 1'($urandom); pu_en_i = 1'($urandom);
            pu_valid_i = 1'($urandom); pu_clear_i = 1'($urandom);
            din1_data_i = {$urandom, $urandom}; din2_data_i = {$urandom, $urandom};
            din3_data_i = {$urandom, $urandom}; temp_rd_data_i = {$urandom, $urandom};
            @(posedge clk_i); #1;
            if ({temp_wr_data_o, temp_wr_valid_o, result_o, result_valid_o, sat_flag_o, out_cnt_o} !== '0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_hold outputs nonzero while rstn_i=0, want all 0"); end
        mux_ctrl_i = 0; pu_en_i = 0; pu_valid_i = 0; pu_clear_i = 0;
        din1_data_i = '0; din2_data_i = '0; din3_data_i = '0; temp_rd_data_i = '0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            if ({temp_wr_data_o, temp_wr_valid_o, result_o, result_valid_o, sat_flag_o, out_cnt_o} !== '0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_idle outputs nonzero after release, want all 0"); end
    endtask

    task automatic test_layer1_relu();
        din1_data_i = lanes2(8'd3, 8'hFD);
        din2_data_i = lanes2(8'd5, 8'd5);
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1) begin errors++; $display("FAIL l1_valid got %b want 1", temp_wr_valid_o); end
        checks++;
        if (temp_wr_data_o[7:0] !== 8'd3) begin errors++; $display("FAIL l1_lane0 got %0h want 03", temp_wr_data_o[7:0]); end
        checks++;
        if (temp_wr_data_o[15:8] !== 8'd0) begin errors++; $display("FAIL l1_relu_lane1 got %0h want 00", temp_wr_data_o[15:8]); end
        checks++;
        if (out_cnt_o !== 8'd1) begin errors++; $display("FAIL l1_cnt got %0d want 1", out_cnt_o); end
        checks++;
        if (result_valid_o !== 1'b0) begin errors++; $display("FAIL l1_no_result got %b want 0", result_valid_o); end
        cyc(0, 0, 0, 0);
        checks++;
        if (temp_wr_valid_o !== 1'b0 || temp_wr_data_o[7:0] !== 8'd3) begin
            errors++; $display("FAIL l1_pulse_hold valid=%b data=%0h want 0/03", temp_wr_valid_o, temp_wr_data_o[7:0]);
        end
    endtask

    task automatic test_clear_collision();
        din1_data_i = lanes2(8'd3, 8'd0);
        din2_data_i = lanes2(8'd5, 8'd0);
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0);
        din1_data_i = lanes2(8'd2, 8'd0);
        din2_data_i = lanes2(8'd7, 8'd0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1 || temp_wr_data_o[7:0] !== 8'd0) begin
            errors++; $display("FAIL clr_en_14 valid=%b data=%0h want 1/00", temp_wr_valid_o, temp_wr_data_o[7:0]);
        end
        din1_data_i = lanes2(8'd16, 8'd0);
        din2_data_i = lanes2(8'd16, 8'd0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_data_o[7:0] !== 8'd16) begin errors++; $display("FAIL clr_en_256 got %0d want 16", temp_wr_data_o[7:0]); end
        // capture leaves the accumulator intact
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1 || temp_wr_data_o[7:0] !== 8'd16 || out_cnt_o !== 8'd4) begin
            errors++; $display("FAIL valid_no_clear valid=%b data=%0d cnt=%0d want 1/16/4",
                               temp_wr_valid_o, temp_wr_data_o[7:0], out_cnt_o);
        end
    endtask

    task automatic test_layer2();
        cyc(0, 0, 1, 0);
        temp_rd_data_i = lanes2(8'd10, 8'd0);
        din3_data_i    = lanes2(8'hFE, 8'd0);
        repeat (8) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (result_valid_o !== 1'b1 || result_o[7:0] !== 8'hF6) begin
            errors++; $display("FAIL l2_result valid=%b data=%0h want 1/f6", result_valid_o, result_o[7:0]);
        end
        checks++;
        if (temp_wr_valid_o !== 1'b0 || out_cnt_o !== 8'd4) begin
            errors++; $display("FAIL l2_no_temp valid=%b cnt=%0d want 0/4", temp_wr_valid_o, out_cnt_o);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1 || result_valid_o !== 1'b0 || temp_wr_data_o[7:0] !== 8'd0 ||
            out_cnt_o !== 8'd5 || result_o[7:0] !== 8'hF6) begin
            errors++; $display("FAIL l2_then_l1 twv=%b rv=%b data=%0h cnt=%0d res=%0h want 1/0/00/5/f6",
                               temp_wr_valid_o, result_valid_o, temp_wr_data_o[7:0], out_cnt_o, result_o[7:0]);
        end
    endtask

    task automatic test_saturation();
        din1_data_i = lanes2(8'd127, 8'd0);
        din2_data_i = lanes2(8'd127, 8'd0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        checks++;
        if (sat_flag_o !== 1'b0) begin errors++; $display("FAIL sat_early got %b want 0", sat_flag_o); end
        cyc(0, 1, 0, 0);
        checks++;
        if (sat_flag_o !== 1'b1) begin errors++; $display("FAIL sat_set got %b want 1", sat_flag_o); end
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_data_o[7:0] !== 8'd127 || out_cnt_o !== 8'd6) begin
            errors++; $display("FAIL sat_quant data=%0d cnt=%0d want 127/6", temp_wr_data_o[7:0], out_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        // clear+en+valid together: the fresh product alone is captured, right after the previous pulse
        din1_data_i = lanes2(8'd2, 8'd0);
        din2_data_i = lanes2(8'd40, 8'd0);
        cyc(0, 1, 1, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1 || temp_wr_data_o[7:0] !== 8'd5 || out_cnt_o !== 8'd7) begin
            errors++; $display("FAIL b2b valid=%b data=%0d cnt=%0d want 1/5/7",
                               temp_wr_valid_o, temp_wr_data_o[7:0], out_cnt_o);
        end
        cyc(0, 0, 1, 0);
        checks++;
        if (sat_flag_o !== 1'b1 || temp_wr_valid_o !== 1'b0) begin
            errors++; $display("FAIL sat_sticky sat=%b valid=%b want 1/0", sat_flag_o, temp_wr_valid_o);
        end
    endtask

    task automatic test_async_reset();
        din1_data_i = lanes2(8'd4, 8'd0);
        din2_data_i = lanes2(8'd4, 8'd0);
        cyc(0, 1, 0, 0);
        pu_en_i = 1'b1;
        #3 rstn_i = 1'b0;
        #1;
        checks++;
        if ({temp_wr_data_o, temp_wr_valid_o, result_o, result_valid_o, sat_flag_o, out_cnt_o} !== '0) begin
            errors++; $display("FAIL async_reset sat=%b cnt=%0d twd=%0h want all 0", sat_flag_o, out_cnt_o, temp_wr_data_o);
        end
        pu_en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        checks++;
        if (temp_wr_valid_o !== 1'b1 || temp_wr_data_o[7:0] !== 8'd1 || out_cnt_o !== 8'd1) begin
            errors++; $display("FAIL post_reset valid=%b data=%0d cnt=%0d want 1/1/1",
                               temp_wr_valid_o, temp_wr_data_o[7:0], out_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_layer1_relu();
        test_clear_collision();
        test_layer2();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Both valid pulses must never be high together
    always @(negedge clk_i) begin
        if (rstn_i && temp_wr_valid_o && result_valid_o) begin
            errors++;
            $display("FAIL both_valid temp=%b result=%b want not both 1", temp_wr_valid_o, result_valid_o);
        end
    end
endmodule
